// File: rtl/uart_tx_framer.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Latency: start bit on the edge after the handshake; one word in flight, o_ready only in IDLE.
module uart_tx_framer #(
    parameter int BAUD_DIV  = 434,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);

    if (BAUD_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_err
        $error("uart_tx_framer: illegal parameter combination");
    end

    localparam int CW = $clog2(BAUD_DIV);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [2:0]           state;
    logic [CW-1:0]        baud_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 par_calc;
    logic                 tx;

    // Even parity bit equals the XOR of the data; odd parity is its inverse.
    assign par_calc = (PARITY == 2) ? ^i_data : ~^i_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
        end else if (state == S_IDLE) begin
            if (i_valid) begin
                shreg    <= i_data;
                par_bit  <= par_calc;
                state    <= S_START;
                tx       <= 1'b0;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end
        end else if (baud_cnt != BAUD_LAST) begin
            baud_cnt <= baud_cnt + CW'(1);
        end else begin
            baud_cnt <= '0;
            case (state)
                S_START: begin
                    state   <= S_DATA;
                    bit_cnt <= '0;
                    tx      <= shreg[0];
                    shreg   <= shreg >> 1;
                end
                S_DATA: begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt <= '0;
                        if (PARITY != 0) begin
                            state <= S_PAR;
                            tx    <= par_bit;
                        end else begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                end
                S_PAR: begin
                    state   <= S_STOP;
                    bit_cnt <= '0;
                    tx      <= 1'b1;
                end
                S_STOP: begin
                    if (bit_cnt == STOP_LAST) begin
                        state   <= S_IDLE;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    assign o_tx    = tx;
    assign o_busy  = (state != S_IDLE);
    assign o_ready = (state == S_IDLE) && rst_n;
    assign o_done  = rst_n && (state == S_STOP) && (baud_cnt == BAUD_LAST) &&
                     (bit_cnt == STOP_LAST);

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: three configurations checked every cycle against a frame-level model.
module tb_uart_tx_framer;

    localparam int NI = 3;
    localparam int BD [NI] = '{4, 3, 5};
    localparam int DB [NI] = '{8, 8, 7};
    localparam int PB [NI] = '{0, 2, 1};
    localparam int SB [NI] = '{1, 1, 2};

    logic       clk;
    logic       rst [NI];
    logic       valid [NI];
    logic [8:0] din [NI];
    logic       rdy [NI];
    logic       tx [NI];
    logic       busy [NI];
    logic       done [NI];

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx_framer #(
            .BAUD_DIV (BD[g]),
            .DATA_BITS(DB[g]),
            .PARITY   (PB[g]),
            .STOP_BITS(SB[g])
        ) u_dut (
            .clk    (clk),
            .rst_n  (rst[g]),
            .i_data (din[g][DB[g]-1:0]),
            .i_valid(valid[g]),
            .o_ready(rdy[g]),
            .o_tx   (tx[g]),
            .o_busy (busy[g]),
            .o_done (done[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures < 40) $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame as a bit vector, bit k = k-th line bit; unused upper bits read as idle-high.
    function automatic logic [15:0] build(input logic [8:0] d, input int db, input int par);
        logic [15:0] b;
        int ones;
        b = 16'hFFFF;
        b[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < db; i++) begin
            b[1+i] = d[i];
            ones += int'(d[i]);
        end
        if (par == 2) b[1+db] = ones[0];
        else if (par == 1) b[1+db] = ~ones[0];
        return b;
    endfunction

    function automatic int nbits(input int g);
        return 1 + DB[g] + ((PB[g] != 0) ? 1 : 0) + SB[g];
    endfunction

    // Model: pos = clk index within the current frame, -1 when idle.
    int          pos [NI] = '{-1, -1, -1};
    int          flen [NI];
    logic [15:0] fb [NI];

    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (!rst[g]) pos[g] = -1;
            else if (pos[g] < 0) begin
                if (valid[g]) begin
                    fb[g]   = build(din[g], DB[g], PB[g]);
                    flen[g] = nbits(g) * BD[g];
                    pos[g]  = 0;
                end
            end else begin
                pos[g]++;
                if (pos[g] == flen[g]) pos[g] = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < NI; g++) begin
                int etx;
                etx = (pos[g] < 0) ? 1 : int'(fb[g][pos[g] / BD[g]]);
                chk($sformatf("tx[%0d]", g), int'(tx[g]), etx);
                chk($sformatf("busy[%0d]", g), int'(busy[g]), int'(pos[g] >= 0));
                chk($sformatf("ready[%0d]", g), int'(rdy[g]), int'(pos[g] < 0 && rst[g]));
                chk($sformatf("done[%0d]", g), int'(done[g]),
                    int'(pos[g] >= 0 && pos[g] == flen[g] - 1 && rst[g]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one word on instance g, sample each bit mid-period, pulse i_valid and scramble i_data mid-frame.
    task automatic cap(input int g, input logic [8:0] d, output logic [15:0] bits,
                       output int done_at, output int rdy_after);
        int len;
        len = nbits(g) * BD[g];
        bits = 16'hFFFF;
        done_at = -1;
        rdy_after = -1;
        din[g] = d;
        valid[g] = 1'b1;
        tick();
        valid[g] = 1'b0;
        din[g] = ~d;
        for (int c = 1; c <= len + 1; c++) begin
            @(negedge clk);
            if ((c - 1) % BD[g] == BD[g] / 2) bits[(c-1) / BD[g]] = tx[g];
            if (done[g] && done_at < 0) done_at = c;
            if (c == len + 1) rdy_after = int'(rdy[g]);
            if (c == 2 * BD[g]) begin
                valid[g] = 1'b1;
                din[g] = 9'h155;
            end
            if (c == 2 * BD[g] + 1) valid[g] = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] bits;
        logic [15:0] lit;
        int done_at, rdy_after, second;

        for (int g = 0; g < NI; g++) begin
            rst[g] = 1'b0;
            valid[g] = 1'b0;
            din[g] = '0;
        end

        lit = build(9'h0A5, 8, 0);
        chk("model_8n1_a5", int'(lit[9:0]), 'h34A);
        lit = build(9'h007, 8, 2);
        chk("model_even_par", int'(lit[9]), 1);
        lit = build(9'h007, 8, 1);
        chk("model_odd_par", int'(lit[9]), 0);

        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        chk("reset_ready", int'(rdy[0]), 0);
        chk("reset_tx", int'(tx[0]), 1);
        for (int g = 0; g < NI; g++) rst[g] = 1'b1;
        tick();

        cap(0, 9'h0A5, bits, done_at, rdy_after);
        chk("8n1_bits", int'(bits[9:0]), 'h34A);
        chk("8n1_done_clk", done_at, 40);
        chk("8n1_ready_after", rdy_after, 1);

        cap(1, 9'h007, bits, done_at, rdy_after);
        chk("8e1_bits", int'(bits[10:0]), 'h60E);
        chk("8e1_done_clk", done_at, 33);

        cap(2, 9'h007, bits, done_at, rdy_after);
        chk("7o2_par_bits", int'(bits[10:0]), 'h60E);
        cap(2, 9'h041, bits, done_at, rdy_after);
        chk("7o2_bits", int'(bits[10:0]), 'h782);
        chk("7o2_done_clk", done_at, 55);

        // Back-to-back with i_valid held: second start bit at clk len+2.
        din[0] = 9'h000;
        valid[0] = 1'b1;
        tick();
        din[0] = 9'h0FF;
        second = -1;
        for (int c = 1; c <= 83; c++) begin
            @(negedge clk);
            if (c > 40 && tx[0] == 1'b0 && second < 0) second = c;
            if (c == 43) valid[0] = 1'b0;
        end
        chk("b2b_second_start", second, 42);

        // Reset pulse during data bit 3 aborts the frame.
        din[0] = 9'h0FF;
        valid[0] = 1'b1;
        tick();
        valid[0] = 1'b0;
        repeat (17) tick();
        rst[0] = 1'b0;
        tick();
        rst[0] = 1'b1;
        @(negedge clk);
        chk("abort_tx", int'(tx[0]), 1);
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_done", int'(done[0]), 0);
        cap(0, 9'h03C, bits, done_at, rdy_after);
        chk("after_abort_bits", int'(bits[9:0]), 'h278);
        chk("after_abort_done", done_at, 40);

        repeat (4000) begin
            tick();
            for (int g = 0; g < NI; g++) begin
                valid[g] = ($urandom_range(3) == 0);
                din[g]   = 9'($urandom);
                rst[g]   = ($urandom_range(399) != 0);
            end
        end
        tick();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
